// File: rtl/shift_issue_stage.sv
// Issue queue in front of an 8-bit shifter: encodes shift requests into
// data/control words and presents them to the shifter in FIFO order.
module shift_issue_stage #(
  parameter int DEPTH = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       IN_VALID,
  output logic       IN_READY,
  input  logic [2:0] OPCODE,
  input  logic [7:0] OPERAND,
  input  logic [7:0] SHAMT,
  output logic       OUT_VALID,
  input  logic       OUT_READY,
  output logic [7:0] SHIFT_DATA,
  output logic [7:0] SHIFT_CTRL,
  output logic       SHIFT_LEFT,
  output logic       ERR
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [7:0] data;
    logic [7:0] ctrl;
    logic       left;
  } entry_t;

  function automatic entry_t encode(input logic [2:0] op, input logic [7:0] operand,
                                    input logic [7:0] shamt);
    entry_t     e;
    logic [3:0] amt;
    amt    = (shamt < 8'd8) ? shamt[3:0] : 4'd8;
    e.data = operand;
    e.left = 1'b0;
    case (op[1:0])
      2'b00: begin
        e.ctrl = {4'b0000, amt};
        e.left = 1'b1;
      end
      2'b01:   e.ctrl = {2'b00, 2'b00, amt};
      2'b10:   e.ctrl = {2'b01, 2'b00, amt};
      2'b11:   e.ctrl = {2'b10, 2'b00, 1'b0, shamt[2:0]};
      default: e.ctrl = 8'h00;
    endcase
    return e;
  endfunction

  entry_t          mem_q [DEPTH];
  entry_t          head_q, head_d, new_s;
  logic [PW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d, base_s;
  logic            ready_q, valid_q, err_q;
  logic            accept_s, illegal_s, push_s, pop_s;

  // Handshake decode, pointer/count next state and next head selection
  always_comb begin
    accept_s  = IN_VALID & ready_q;
    illegal_s = OPCODE[2];
    push_s    = accept_s & ~illegal_s;
    pop_s     = valid_q & OUT_READY;
    new_s     = encode(OPCODE, OPERAND, SHAMT);

    if (push_s) begin
      wptr_d = wptr_q + PW'(1);
    end else begin
      wptr_d = wptr_q;
    end
    if (pop_s) begin
      rptr_d = rptr_q + PW'(1);
    end else begin
      rptr_d = rptr_q;
    end

    count_d = count_q + CW'(push_s) - CW'(pop_s);
    base_s  = count_q - CW'(pop_s);

    // When nothing older survives this edge the new head is the entry being written now
    head_d = head_q;
    if (count_d != {CW{1'b0}}) begin
      if (base_s == {CW{1'b0}}) begin
        head_d = new_s;
      end else begin
        head_d = mem_q[rptr_d];
      end
    end else begin
      head_d = head_q;
    end
  end

  // Queue storage, pointers and registered handshake/head outputs
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q  <= {PW{1'b0}};
      rptr_q  <= {PW{1'b0}};
      count_q <= {CW{1'b0}};
      head_q  <= '0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (push_s) begin
        mem_q[wptr_q] <= new_s;
      end
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      head_q  <= head_d;
      ready_q <= (count_d < CW'(DEPTH));
      valid_q <= (count_d != {CW{1'b0}});
      err_q   <= accept_s & illegal_s;
    end
  end

  assign IN_READY   = ready_q;
  assign OUT_VALID  = valid_q;
  assign SHIFT_DATA = head_q.data;
  assign SHIFT_CTRL = head_q.ctrl;
  assign SHIFT_LEFT = head_q.left;
  assign ERR        = err_q;

endmodule
